// File: rtl/gate2_tester_pkg.sv
// Shared definitions for the 2-input gate tester: FSM state encoding,
// truth-table constants for the common gates and small helpers.
package gate2_tester_pkg;

    // Number of input vectors for a 2-input gate and their index width.
    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    // Width of the settle counter. Supported settle times are 1..255 cycles.
    localparam int CNT_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    // Expected Y per vector index {A,B}. Bit k holds Y for vector k.
    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;

    // Observed Y differs from the expected bit. A case inequality is used
    // so that an unknown Y counts as a mismatch in simulation.
    function automatic logic is_mismatch(input logic y, input logic exp_y);
        return (y !== exp_y);
    endfunction

    // Last vector of the sequence; reaching it ends the run.
    function automatic logic is_last_vec(input logic [VEC_W-1:0] vec);
        return (vec == VEC_W'(NUM_VEC - 1));
    endfunction

endpackage

// File: rtl/gate2_tester_if.sv
// Signals between the gate tester and its surroundings: the start button,
// the gate under test and the result outputs.
interface gate2_tester_if;
    import gate2_tester_pkg::*;

    logic               start;     // run request, level sensitive
    logic               y;         // gate output under test
    logic               a;         // gate input A
    logic               b;         // gate input B
    logic               busy;      // run in progress
    logic               done;      // one-cycle completion pulse
    logic               pass;      // all vectors matched
    logic [NUM_VEC-1:0] err_mask;  // per-vector mismatch flags
    logic [VEC_W-1:0]   vec;       // vector currently applied

    // Tester side: drives the gate inputs and the result outputs.
    modport master (
        input  start,
        input  y,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_mask,
        output vec
    );

    // Board side: requests runs, provides Y and observes results.
    modport slave (
        output start,
        output y,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_mask,
        input  vec
    );

endinterface

// File: rtl/gate2_tester_settle_timer.sv
// Settle-time counter for the gate tester. Counts while enabled, returns to
// zero on clear, and flags terminal count when it reaches SETTLE-1.
module gate2_tester_settle_timer
    import gate2_tester_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable so each vector starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate2_tester.sv
// Exhaustive tester for one 2-input gate. Applies the four {A,B} vectors in
// order, lets each settle for SETTLE+1 clock periods, compares Y against the
// TRUTH table and reports a per-vector error mask and an overall pass flag.
module gate2_tester
    import gate2_tester_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TRUTH  = TT_AND,
    parameter int                 SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gate2_tester_if.master bus
);

    state_e             state_q;
    logic [VEC_W-1:0]   vec_q;
    logic               a_q;
    logic               b_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [NUM_VEC-1:0] err_q;

    logic [NUM_VEC-1:0] err_d;
    logic [VEC_W-1:0]   vec_d;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;

    // The counter only runs while settling; leaving SETTLE (or sitting in
    // IDLE) holds it at zero, so every vector starts a fresh count.
    assign tmr_en  = (state_q == ST_SETTLE);
    assign tmr_clr = (state_q != ST_SETTLE);

    gate2_tester_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Error mask with the current vector's compare folded in, and the index
    // of the following vector; both are consumed on the sample edge.
    always_comb begin
        err_d        = err_q;
        err_d[vec_q] = is_mismatch(bus.y, TRUTH[vec_q]);
        vec_d        = vec_q + VEC_W'(1);
    end

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // START is only looked at here, so it cannot restart a
                    // run that is already in progress.
                    if (bus.start) begin
                        state_q <= ST_SETTLE;
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (tmr_tc) begin
                        state_q <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    err_q <= err_d;
                    if (!is_last_vec(vec_q)) begin
                        vec_q   <= vec_d;
                        a_q     <= vec_d[1];
                        b_q     <= vec_d[0];
                        state_q <= ST_SETTLE;
                    end else begin
                        // The last compare is part of err_d, so PASS sees
                        // the complete mask.
                        vec_q   <= '0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    vec_q   <= '0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_mask = err_q;
    assign bus.vec      = vec_q;

endmodule

// File: tb/tb_gate2_tester.sv
// Bench for gate2_tester. Three testers run side by side from one START and
// one reset: AND table with SETTLE=2, OR table with SETTLE=2, and AND table
// with SETTLE=1. Each drives its own gate model, selectable per run.
module tb_gate2_tester;
    import gate2_tester_pkg::*;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Gate model selection per tester:
    // 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 stuck-0, 6 stuck-1, 7 AND delayed one cycle
    int mode [NI];

    logic [NI-1:0] y_w;
    logic [NI-1:0] dly_q;
    logic [NI-1:0] a_w, b_w, busy_w, done_w, pass_w;
    logic [3:0]    mask_w [NI];
    logic [1:0]    vec_w  [NI];

    // Reference state: cycles since the accepted START edge, and the
    // result left behind by the last completed run.
    int         rel      [NI];
    logic [3:0] fin_mask [NI];
    logic       fin_pass [NI];

    always #5 clk = ~clk;

    gate2_tester_if bus0 ();
    gate2_tester_if bus1 ();
    gate2_tester_if bus2 ();

    gate2_tester #(.TRUTH(TT_AND), .SETTLE(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate2_tester #(.TRUTH(TT_OR),  .SETTLE(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gate2_tester #(.TRUTH(TT_AND), .SETTLE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.start = start;
    assign bus1.start = start;
    assign bus2.start = start;
    assign bus0.y     = y_w[0];
    assign bus1.y     = y_w[1];
    assign bus2.y     = y_w[2];

    assign {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0]} = {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass};
    assign {a_w[1], b_w[1], busy_w[1], done_w[1], pass_w[1]} = {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass};
    assign {a_w[2], b_w[2], busy_w[2], done_w[2], pass_w[2]} = {bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass};
    assign mask_w[0] = bus0.err_mask;
    assign mask_w[1] = bus1.err_mask;
    assign mask_w[2] = bus2.err_mask;
    assign vec_w[0]  = bus0.vec;
    assign vec_w[1]  = bus1.vec;
    assign vec_w[2]  = bus2.vec;

    function automatic int settle_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic logic [3:0] truth_of(input int i);
        return (i == 1) ? TT_OR : TT_AND;
    endfunction

    // Truth table of each gate model, indexed by {A,B}.
    function automatic logic [3:0] gate_tt(input int m);
        case (m)
            0:       return TT_AND;
            1:       return TT_OR;
            2:       return TT_XOR;
            3:       return TT_NAND;
            4:       return TT_NOR;
            5:       return 4'b0000;
            6:       return 4'b1111;
            default: return TT_AND;
        endcase
    endfunction

    function automatic logic gate_out(input int m, input logic [1:0] v);
        logic [3:0] t;
        t = gate_tt(m);
        return t[v];
    endfunction

    // Gate models seen by the testers.
    always_comb begin
        y_w = '0;
        for (int i = 0; i < NI; i++) begin
            y_w[i] = (mode[i] == 7) ? dly_q[i] : gate_out(mode[i], {a_w[i], b_w[i]});
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            dly_q[i] <= gate_out(0, {a_w[i], b_w[i]});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            rel[i]      = 4 * (settle_of(i) + 1) + 1;
            fin_mask[i] = '0;
            fin_pass[i] = 1'b0;
        end
    endtask

    // Advance the reference by one clock edge, using the START level that
    // was present at that edge.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            int p;
            p = settle_of(i) + 1;
            if (rel[i] >= 4 * p && start) begin
                rel[i] = 0;
            end else if (rel[i] < 1000) begin
                rel[i]++;
            end
            if (rel[i] == 4 * p) begin
                fin_mask[i] = gate_tt(mode[i]) ^ truth_of(i);
                fin_pass[i] = (fin_mask[i] == 4'b0000);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int         p;
            int         r;
            logic [3:0] full;
            logic [3:0] em;
            logic       eb;
            logic       ed;
            logic       ep;
            logic [1:0] ev;
            p    = settle_of(i) + 1;
            r    = rel[i];
            full = gate_tt(mode[i]) ^ truth_of(i);
            if (r < 4 * p) begin
                // Vector k is applied at offset k*p and judged at (k+1)*p.
                eb = 1'b1;
                ed = 1'b0;
                ep = 1'b0;
                ev = 2'(r / p);
                em = '0;
                for (int k = 0; k < 4; k++) begin
                    if ((k + 1) * p <= r) em[k] = full[k];
                end
            end else begin
                eb = 1'b0;
                ed = (r == 4 * p);
                ep = fin_pass[i];
                ev = 2'b00;
                em = fin_mask[i];
            end
            check_val($sformatf("u%0d busy r=%0d", i, r), 32'(busy_w[i]), 32'(eb));
            check_val($sformatf("u%0d done r=%0d", i, r), 32'(done_w[i]), 32'(ed));
            check_val($sformatf("u%0d pass r=%0d", i, r), 32'(pass_w[i]), 32'(ep));
            check_val($sformatf("u%0d err_mask r=%0d", i, r), 32'(mask_w[i]), 32'(em));
            check_val($sformatf("u%0d vec r=%0d", i, r), 32'(vec_w[i]), 32'(ev));
            check_val($sformatf("u%0d a r=%0d", i, r), 32'(a_w[i]), 32'(ev[1]));
            check_val($sformatf("u%0d b r=%0d", i, r), 32'(b_w[i]), 32'(ev[0]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_step();
            check_all();
        end
    endtask

    // Reset asserted between edges must clear every output before any clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d async rst outputs", i),
                      32'({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i], vec_w[i]}),
                      32'd0);
        end
        model_reset();
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2);
        mode[0] = m0;
        mode[1] = m1;
        mode[2] = m2;
    endtask

    // One run: START for the t0 edge, optional extra START at edge t0+pulse_at,
    // optional reset just after edge t0+rst_at, then drain to idle.
    task automatic run(input bit hold, input int pulse_at, input int rst_at, input int len);
        start = 1'b1;
        tick(1);
        for (int c = 1; c <= len; c++) begin
            start = hold || (c == pulse_at);
            tick(1);
            if (c == rst_at) async_reset();
        end
        start = 1'b0;
        tick(13);
    endtask

    initial begin
        set_modes(0, 1, 0);
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d reset outputs", i),
                      32'({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i], vec_w[i]}),
                      32'd0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Matching gates, including a one-cycle-late AND on the SETTLE=1 tester.
        set_modes(0, 1, 7);
        run(1'b0, -1, -1, 16);
        // OR gate against the AND table; stuck-1 against OR.
        set_modes(1, 6, 0);
        run(1'b0, -1, -1, 16);
        // Stuck-1 against AND, XOR against OR, stuck-0 against AND; long idle hold.
        set_modes(6, 2, 5);
        run(1'b0, -1, -1, 24);
        // START again mid-run, then START held high across back-to-back runs.
        set_modes(0, 1, 0);
        run(1'b0, 5, -1, 16);
        run(1'b1, -1, -1, 30);
        // Reset while vector 2 is applied, then a clean run.
        set_modes(0, 3, 4);
        run(1'b0, -1, 7, 16);
        set_modes(0, 1, 0);
        run(1'b0, -1, -1, 16);

        // Randomized runs.
        for (int n = 0; n < 25; n++) begin
            bit hold;
            int pulse_at;
            int rst_at;
            int len;
            set_modes(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            hold     = ($urandom_range(0, 3) == 0);
            pulse_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
            rst_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1;
            len      = 14 + int'($urandom_range(0, 6));
            run(hold, pulse_at, rst_at, len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
